// File: rtl/ps2_timer_arbiter.sv
// ps2_timer_arbiter: round-robin owner selection for the single shared PS/2
// countdown timer. It latches the winner's interval, pulses the timer start,
// and hands the timer's done pulse back to the winner as an expiry strobe.
module ps2_timer_arbiter #(
    parameter int N  = 4,
    parameter int IW = 16
) (
    input  logic            i_Clk,
    input  logic            i_nReset,
    input  logic [N-1:0]    i_Req,
    input  logic [N*IW-1:0] i_ReqInterval,
    input  logic            i_TmrDone,
    output logic [N-1:0]    o_Grant,
    output logic [N-1:0]    o_Expired,
    output logic            o_Busy,
    output logic            o_TmrStart,
    output logic [IW-1:0]   o_TmrInterval
);

    localparam int CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_WAIT  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t          r_state;
    logic [CW-1:0]   r_cur;
    logic [CW-1:0]   r_last;
    logic [N-1:0]    r_grant;
    logic [N-1:0]    r_expired;
    logic            r_busy;
    logic            r_tmr_start;
    logic [IW-1:0]   r_tmr_interval;

    logic            w_found;
    logic [CW-1:0]   w_win;
    logic [CW-1:0]   w_idx;
    logic [IW-1:0]   w_win_iv;

    function automatic logic [N-1:0] onehot(input logic [CW-1:0] idx);
        logic [N-1:0] v;
        v = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

    // Round-robin search: first requester after the last winner, wrapping mod N.
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        w_idx   = r_last;
        for (int k = 0; k < N; k++) begin
            w_idx = (w_idx == CW'(N - 1)) ? '0 : w_idx + CW'(1);
            if (!w_found && i_Req[w_idx]) begin
                w_found = 1'b1;
                w_win   = w_idx;
            end
        end
    end

    // Interval of the candidate winner; only consumed on the grant edge.
    always_comb begin
        w_win_iv = '0;
        for (int i = 0; i < N; i++) begin
            if (w_win == CW'(i)) w_win_iv = i_ReqInterval[i*IW +: IW];
        end
    end

    // Control FSM; outputs are loaded together with the state they belong to.
    always_ff @(posedge i_Clk or negedge i_nReset) begin
        if (!i_nReset) begin
            r_state        <= S_IDLE;
            r_cur          <= '0;
            r_last         <= CW'(N - 1);
            r_grant        <= '0;
            r_expired      <= '0;
            r_busy         <= 1'b0;
            r_tmr_start    <= 1'b0;
            r_tmr_interval <= '0;
        end else begin
            r_tmr_start <= 1'b0;
            r_expired   <= '0;
            case (r_state)
                S_IDLE: begin
                    // Stale done pulses from aborted runs land here and are dropped.
                    if (w_found) begin
                        r_cur          <= w_win;
                        r_last         <= w_win;
                        r_tmr_interval <= w_win_iv;
                        r_grant        <= onehot(w_win);
                        r_busy         <= 1'b1;
                        if (w_win_iv != '0) begin
                            r_state     <= S_START;
                            r_tmr_start <= 1'b1;
                        end else begin
                            // Zero would make the timer wrap; expire without running it.
                            r_state   <= S_DONE;
                            r_expired <= onehot(w_win);
                        end
                    end
                end
                S_START: begin
                    if (!i_Req[r_cur]) begin
                        r_state <= S_IDLE;
                        r_grant <= '0;
                        r_busy  <= 1'b0;
                    end else begin
                        r_state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    // Abort has priority over a done pulse in the same cycle.
                    if (!i_Req[r_cur]) begin
                        r_state <= S_IDLE;
                        r_grant <= '0;
                        r_busy  <= 1'b0;
                    end else if (i_TmrDone) begin
                        r_state   <= S_DONE;
                        r_expired <= onehot(r_cur);
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    r_grant <= '0;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_grant <= '0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign o_Grant       = r_grant;
    assign o_Expired     = r_expired;
    assign o_Busy        = r_busy;
    assign o_TmrStart    = r_tmr_start;
    assign o_TmrInterval = r_tmr_interval;

endmodule

// File: tb/tb_ps2_timer_arbiter.sv
// Directed bench for ps2_timer_arbiter with a behavioural countdown timer.
module tb_ps2_timer_arbiter;

    localparam int N  = 4;
    localparam int IW = 16;

    logic            clk = 1'b0;
    logic            nrst = 1'b0;
    logic [N-1:0]    req = '0;
    logic [N*IW-1:0] req_iv = '0;
    logic            inj_done = 1'b0;
    logic            tmr_done;
    logic [N-1:0]    grant;
    logic [N-1:0]    expired;
    logic            busy;
    logic            tmr_start;
    logic [IW-1:0]   tmr_interval;

    int   checks = 0;
    int   errors = 0;
    int   n;
    int   tm_cnt = 0;
    logic tm_done = 1'b0;

    always #5 clk = ~clk;

    assign tmr_done = tm_done | inj_done;

    ps2_timer_arbiter #(.N(N), .IW(IW)) dut (
        .i_Clk         (clk),
        .i_nReset      (nrst),
        .i_Req         (req),
        .i_ReqInterval (req_iv),
        .i_TmrDone     (tmr_done),
        .o_Grant       (grant),
        .o_Expired     (expired),
        .o_Busy        (busy),
        .o_TmrStart    (tmr_start),
        .o_TmrInterval (tmr_interval)
    );

    // Timer model: load on start, count down, one-cycle done after reaching 1.
    always @(posedge clk) begin
        tm_done <= 1'b0;
        if (tmr_start) begin
            tm_cnt <= int'(tmr_interval);
        end else if (tm_cnt != 0) begin
            tm_cnt <= tm_cnt - 1;
            if (tm_cnt == 1) tm_done <= 1'b1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    // Step until the timer's done is visible, bounded; returns cycles waited.
    task automatic wait_done(input int max, output int cnt);
        cnt = 0;
        do begin
            step();
            cnt++;
        end while (!tmr_done && cnt < max);
        chk("done_seen", 32'(tmr_done), 32'd1);
    endtask

    task automatic do_reset();
        req  = '0;
        nrst = 1'b0;
        step();
        step();
        nrst = 1'b1;
        step();
    endtask

    initial begin
        // ---- reset state
        step();
        chk("rst_grant", 32'(grant), 32'h0);
        chk("rst_expired", 32'(expired), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_start", 32'(tmr_start), 32'h0);
        chk("rst_iv", 32'(tmr_interval), 32'h0);
        nrst = 1'b1;
        step();

        // ---- single request, interval 5
        req_iv[0*IW +: IW] = 16'd5;
        req = 4'b0001;
        step();
        chk("t1_grant", 32'(grant), 32'h1);
        chk("t1_start", 32'(tmr_start), 32'h1);
        chk("t1_iv", 32'(tmr_interval), 32'd5);
        chk("t1_busy", 32'(busy), 32'h1);
        wait_done(30, n);
        chk("t1_len", 32'(n), 32'd6);
        chk("t1_exp_early", 32'(expired), 32'h0);
        step();
        chk("t1_expired", 32'(expired), 32'h1);
        chk("t1_busy_hold", 32'(busy), 32'h1);
        req = '0;
        step();
        chk("t1_expired_off", 32'(expired), 32'h0);
        chk("t1_busy_fall", 32'(busy), 32'h0);

        // ---- all requesting, round-robin 0,1,2,3,0
        do_reset();
        for (int i = 0; i < N; i++) req_iv[i*IW +: IW] = 16'd3;
        req = 4'b1111;
        step();
        for (int g = 0; g < 5; g++) begin
            chk("rr_grant", 32'(grant), 32'(1 << (g % N)));
            chk("rr_start", 32'(tmr_start), 32'h1);
            chk("rr_iv", 32'(tmr_interval), 32'd3);
            wait_done(20, n);
            chk("rr_len", 32'(n), 32'd4);
            step();
            chk("rr_expired", 32'(expired), 32'(1 << (g % N)));
            if (g == 4) req = '0;
            step();
            chk("rr_idle_grant", 32'(grant), 32'h0);
            chk("rr_idle_busy", 32'(busy), 32'h0);
            step();
        end
        chk("rr_quiet", 32'(grant), 32'h0);

        // ---- zero interval on requester 2
        req_iv[2*IW +: IW] = 16'd0;
        req = 4'b0100;
        step();
        chk("z_grant", 32'(grant), 32'h4);
        chk("z_expired", 32'(expired), 32'h4);
        chk("z_start", 32'(tmr_start), 32'h0);
        req = '0;
        step();
        chk("z_start2", 32'(tmr_start), 32'h0);
        chk("z_idle", 32'(busy), 32'h0);

        // ---- abort requester 1 mid-WAIT, then requester 3 with interval 4
        req_iv[1*IW +: IW] = 16'd100;
        req = 4'b0010;
        step();
        chk("ab_grant", 32'(grant), 32'h2);
        chk("ab_start", 32'(tmr_start), 32'h1);
        step();
        step();
        chk("ab_wait_grant", 32'(grant), 32'h2);
        req = '0;
        step();
        chk("ab_grant_off", 32'(grant), 32'h0);
        chk("ab_no_exp", 32'(expired), 32'h0);
        req_iv[3*IW +: IW] = 16'd4;
        req = 4'b1000;
        step();
        chk("ab3_grant", 32'(grant), 32'h8);
        chk("ab3_start", 32'(tmr_start), 32'h1);
        chk("ab3_iv", 32'(tmr_interval), 32'd4);
        wait_done(20, n);
        chk("ab3_len", 32'(n), 32'd5);
        step();
        chk("ab3_expired", 32'(expired), 32'h8);
        req = '0;
        step();
        step();
        inj_done = 1'b1;
        step();
        inj_done = 1'b0;
        chk("stale_exp", 32'(expired), 32'h0);
        step();
        chk("stale_exp2", 32'(expired), 32'h0);
        chk("stale_busy", 32'(busy), 32'h0);

        // ---- drop coincident with TmrDone
        req_iv[0*IW +: IW] = 16'd3;
        req = 4'b0001;
        step();
        chk("co_grant", 32'(grant), 32'h1);
        wait_done(20, n);
        req = '0;
        step();
        chk("co_no_exp", 32'(expired), 32'h0);
        chk("co_idle", 32'(busy), 32'h0);
        chk("co_grant_off", 32'(grant), 32'h0);

        // ---- async reset during WAIT
        req_iv[0*IW +: IW] = 16'd10;
        req = 4'b0001;
        step();
        chk("rw_grant", 32'(grant), 32'h1);
        step();
        #2;
        nrst = 1'b0;
        req  = '0;
        #1;
        chk("rw_grant0", 32'(grant), 32'h0);
        chk("rw_busy0", 32'(busy), 32'h0);
        chk("rw_start0", 32'(tmr_start), 32'h0);
        chk("rw_exp0", 32'(expired), 32'h0);
        step();
        step();
        nrst = 1'b1;
        for (int c = 0; c < 14; c++) begin
            step();
            chk("rw_no_exp", 32'(expired), 32'h0);
        end
        req = 4'b0011;
        step();
        chk("rw_next_grant", 32'(grant), 32'h1);
        req = '0;
        step();
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ps2_timer_arbiter.md
# ps2_timer_arbiter

Shares the single 16-bit PS/2 countdown timer between up to N independent timeout requesters, such as the host-inhibit delay, the RX bit watchdog and the command-response timeout. It arbitrates round-robin and latches the winner's interval. It drives the timer's start pulse and interval, then routes the timer's done pulse back to the winner as a one-cycle expiry strobe. It sits between the PS/2 protocol FSMs and the timer instance.

## Interface
- N, default 4: number of requesters (2..8).
- IW, default 16: interval width; matches the timer.
- Clk  in  1  system clock; all state changes on its rising edge.
- nReset  in  1  asynchronous, active-low reset.
- Req  in  N  per-requester level request; held high while the timeout is wanted; dropping it aborts.
- ReqInterval  in  N*IW  interval for requester i, in bits [i*IW +: IW]; sampled only at grant.
- TmrDone  in  1  done pulse from the shared timer.
- Grant  out  N  one-hot; the requester currently owning the timer.
- Expired  out  N  one-hot, one-cycle strobe; the granted requester's timeout elapsed.
- Busy  out  1  high in any state other than IDLE.
- TmrStart  out  1  one-cycle start pulse to the timer.
- TmrInterval  out  IW  interval presented to the timer; held stable from START until the next grant.

## Operation
- The FSM has four states: IDLE, START, WAIT and DONE. A registered index `Cur` identifies the winner. A round-robin pointer `Last` records the last granted index.
- IDLE, with any Req bit high:
  - Select the first high Req in the order Last+1, Last+2, … (mod N).
  - Latch Cur ← winner and Last ← winner, and latch the winner's interval into TmrInterval.
  - Go to START if the latched interval ≠ 0. Otherwise go to DONE; a zero interval must never reach the timer, because the timer would wrap.
- IDLE with no request: stay in IDLE. TmrDone is ignored there, since stale pulses from an aborted run can arrive.
- START: TmrStart = 1 for exactly this cycle. Next state is WAIT; it is IDLE if Req[Cur] = 0.
- WAIT: stay until TmrDone = 1, then go to DONE. TmrDone counts only in WAIT. If Req[Cur] = 0, go to IDLE with no Expired; this abort wins over a simultaneous TmrDone.
- DONE: Expired[Cur] = 1 for this cycle, regardless of Req. Next state is IDLE.
- Grant[Cur] is high in START, WAIT and DONE, and all Grant bits are 0 in IDLE.
- A requester that keeps Req high after Expired is re-arbitrated in IDLE as a new request. Because the pointer has advanced, other pending requesters win first.
- Aborted timer runs are not cancelled in the timer. Either the next TmrStart reloads the timer, or its done pulse lands in IDLE and is discarded.

## Timing
- Reset values: state IDLE, Last = N−1 (index 0 wins first), Cur = 0, Grant = 0, Expired = 0, Busy = 0, TmrStart = 0, TmrInterval = 0.
- Reset is asynchronous and may assert in any state. No Expired is emitted afterwards, and a running timer's later TmrDone is ignored.
- All outputs are registered or decoded from registered state, with no combinational path from Req or TmrDone to an output.
- Req seen high in IDLE at edge t:
  - t+1: Grant and TmrStart high, TmrInterval valid.
  - t+2: WAIT.
- TmrDone seen high in WAIT at edge u: Expired is high during cycle u+1, and the FSM is back in IDLE at u+2.
- Zero interval, Req seen at edge t: Grant and Expired are both high during cycle t+1, with TmrStart never asserted.
- Minimum spacing between consecutive grants is 1 IDLE cycle.
- Changes to ReqInterval[Cur] after the grant have no effect.

## Test plan
- Reset, then Req = 0001 with interval 5 and a timer model attached:
  - TmrStart pulses once, TmrInterval = 5.
  - Expired = 0001 exactly one cycle after TmrDone.
  - Busy falls 2 cycles after TmrDone.
- Req = 1111 held continuously, all intervals 3: grants are issued in order 0, 1, 2, 3, 0, with one Expired per grant and one IDLE cycle between grants.
- Req[2] with interval 0: Grant = 0100 and Expired = 0100 in the same cycle, one cycle after the request, and TmrStart stays 0.
- Req[1] with interval 100, dropped mid-WAIT, then Req[3] with interval 4 raised:
  - No Expired[1].
  - Grant = 1000 with a new TmrStart, and Expired = 1000 after the 4-tick run.
  - A forced stale TmrDone injected while in IDLE produces no Expired.
- Req[0] drop coincident with TmrDone in WAIT: no Expired, and the FSM is back in IDLE one cycle later.
- nReset pulsed low in WAIT: Grant, Busy, TmrStart and Expired go to 0 immediately, with no Expired after release. The next request from Req = 0011 grants index 0.
